// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: recovers HPOS/VPOS from incoming HSYNC/VSYNC pulses,
// measures line/frame timing and reports lock once it is stable.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SEARCH   | waiting for the first frame boundary
// MEASURE  | one full frame observed to capture reference line/frame size
// CHECK    | counting consecutive frames that match the references
// LOCKED   | timing stable; LINE_LEN/FRAME_LINES valid, ACTIVE enabled
module vga_sync_decoder #(
    parameter int HDAT_BEGIN  = 143,
    parameter int HDAT_END    = 783,
    parameter int VDAT_BEGIN  = 34,
    parameter int VDAT_END    = 514,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HSYNC,
    input  logic       VSYNC,
    output logic [9:0] HPOS,
    output logic [9:0] VPOS,
    output logic       ACTIVE,
    output logic       LOCKED,
    output logic [9:0] LINE_LEN,
    output logic [9:0] FRAME_LINES,
    output logic       ERR
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [9:0] POS_MAX = 10'd1023;
    localparam logic [9:0] H_BEG   = 10'(HDAT_BEGIN);
    localparam logic [9:0] H_END   = 10'(HDAT_END);
    localparam logic [9:0] V_BEG   = 10'(VDAT_BEGIN);
    localparam logic [9:0] V_END   = 10'(VDAT_END);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    state_t     state_q, state_d;
    logic       hs_s1_q, hs_s2_q, hs_s3_q, hs_s1_d, hs_s2_d, hs_s3_d;
    logic       vs_s1_q, vs_s2_q, vs_s3_q, vs_s1_d, vs_s2_d, vs_s3_d;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       vs_pend_q, vs_pend_d;
    logic [9:0] ref_line_q, ref_line_d;
    logic [9:0] ref_frame_q, ref_frame_d;
    logic [9:0] first_line_q, first_line_d;
    logic       first_pend_q, first_pend_d;
    logic       mism_q, mism_d;
    logic [3:0] match_q, match_d;
    logic       err_q, err_d;

    logic       hs_fall, vs_fall, boundary, timeout;
    logic       line_ok, frame_ok;
    logic [9:0] first_eff;

    always_comb begin
        hs_s1_d = HSYNC;
        hs_s2_d = hs_s1_q;
        hs_s3_d = hs_s2_q;
        vs_s1_d = VSYNC;
        vs_s2_d = vs_s1_q;
        vs_s3_d = vs_s2_q;

        hs_fall  = hs_s3_q & ~hs_s2_q;
        vs_fall  = vs_s3_q & ~vs_s2_q;
        boundary = hs_fall & (vs_pend_q | vs_fall);
        timeout  = (hpos_q == POS_MAX) || (vpos_q == POS_MAX);

        // hpos_q/vpos_q at an hsync fall are the just-finished line/frame sizes
        line_ok   = (hpos_q == ref_line_q);
        frame_ok  = !mism_q && line_ok && (vpos_q == ref_frame_q);
        first_eff = first_pend_q ? hpos_q : first_line_q;

        hpos_d = hs_fall ? 10'd0 : ((hpos_q == POS_MAX) ? POS_MAX : hpos_q + 10'd1);

        vpos_d = vpos_q;
        if (boundary) begin
            vpos_d = 10'd0;
        end else if (hs_fall && (vpos_q != POS_MAX)) begin
            vpos_d = vpos_q + 10'd1;
        end

        vs_pend_d = boundary ? 1'b0 : (vs_fall | vs_pend_q);

        mism_d       = mism_q;
        first_line_d = first_line_q;
        first_pend_d = first_pend_q;
        if (boundary) begin
            mism_d       = 1'b0;
            first_pend_d = 1'b1;
        end else if (hs_fall) begin
            if (!line_ok) begin
                mism_d = 1'b1;
            end
            if (first_pend_q) begin
                first_line_d = hpos_q;
                first_pend_d = 1'b0;
            end
        end

        state_d     = state_q;
        ref_line_d  = ref_line_q;
        ref_frame_d = ref_frame_q;
        match_d     = match_q;
        err_d       = 1'b0;

        if (timeout) begin
            state_d = ST_SEARCH;
            err_d   = (state_q != ST_SEARCH);
        end else if (boundary) begin
            unique case (state_q)
                ST_SEARCH: begin
                    state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    ref_line_d  = first_eff;
                    ref_frame_d = vpos_q;
                    match_d     = 4'd0;
                    state_d     = ST_CHECK;
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == LOCK_N) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_line_d  = first_eff;
                        ref_frame_d = vpos_q;
                        match_d     = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_ok) begin
                        state_d = ST_SEARCH;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_SEARCH;
            hs_s1_q      <= 1'b1;
            hs_s2_q      <= 1'b1;
            hs_s3_q      <= 1'b1;
            vs_s1_q      <= 1'b1;
            vs_s2_q      <= 1'b1;
            vs_s3_q      <= 1'b1;
            hpos_q       <= 10'd0;
            vpos_q       <= 10'd0;
            vs_pend_q    <= 1'b0;
            ref_line_q   <= 10'd0;
            ref_frame_q  <= 10'd0;
            first_line_q <= 10'd0;
            first_pend_q <= 1'b0;
            mism_q       <= 1'b0;
            match_q      <= 4'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_s1_q      <= hs_s1_d;
            hs_s2_q      <= hs_s2_d;
            hs_s3_q      <= hs_s3_d;
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            vs_s3_q      <= vs_s3_d;
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            vs_pend_q    <= vs_pend_d;
            ref_line_q   <= ref_line_d;
            ref_frame_q  <= ref_frame_d;
            first_line_q <= first_line_d;
            first_pend_q <= first_pend_d;
            mism_q       <= mism_d;
            match_q      <= match_d;
            err_q        <= err_d;
        end
    end

    assign HPOS        = hpos_q;
    assign VPOS        = vpos_q;
    assign LOCKED      = (state_q == ST_LOCKED);
    assign ERR         = err_q;
    assign LINE_LEN    = LOCKED ? ref_line_q : 10'd0;
    assign FRAME_LINES = LOCKED ? ref_frame_q : 10'd0;
    assign ACTIVE      = LOCKED && (hpos_q >= H_BEG) && (hpos_q < H_END)
                         && (vpos_q >= V_BEG) && (vpos_q < V_END);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: a compact sync generator (100x10 frames,
// plus a tall mixed-length frame for the data window) drives the decoder.
module tb_vga_sync_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       HSYNC = 1'b1;
    logic       VSYNC = 1'b1;
    logic [9:0] HPOS, VPOS, LINE_LEN, FRAME_LINES;
    logic       ACTIVE, LOCKED, ERR;

    int errs = 0;
    int checks = 0;

    bit gen_en = 0, hs_kill = 0, stretch_req = 0;
    int next_mode = 0, mode = 0;
    int h_cnt = 0, v_cnt = 0, cur_len = 100;
    int drv_h = -1, drv_v = -1, vf_cnt = 0;

    vga_sync_decoder dut (
        .CLK(CLK), .RST(RST), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .HPOS(HPOS), .VPOS(VPOS), .ACTIVE(ACTIVE), .LOCKED(LOCKED),
        .LINE_LEN(LINE_LEN), .FRAME_LINES(FRAME_LINES), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // mode 0: 100-cycle lines, 10 lines. mode 1: 520 lines, mostly 8 cycles,
    // with full 800-cycle lines around the top and bottom of the data window.
    function automatic int len_of(input int m, input int v);
        if (m == 1) return (v == 33 || v == 34 || v == 513 || v == 514) ? 800 : 8;
        return 100;
    endfunction

    function automatic int lines_of(input int m);
        return (m == 1) ? 520 : 10;
    endfunction

    initial begin : gen
        forever begin
            @(negedge CLK);
            if (gen_en) begin
                if (h_cnt == 0) begin
                    if (v_cnt == 0) begin
                        mode = next_mode;
                        vf_cnt++;
                    end
                    cur_len = len_of(mode, v_cnt);
                    if (stretch_req && v_cnt == 3) begin
                        cur_len += 2;
                        stretch_req = 0;
                    end
                end
                drv_h = h_cnt;
                drv_v = v_cnt;
                HSYNC = hs_kill ? 1'b1 : (h_cnt >= 4);
                VSYNC = (v_cnt >= 2);
                h_cnt++;
                if (h_cnt == cur_len) begin
                    h_cnt = 0;
                    v_cnt++;
                    if (v_cnt == lines_of(mode)) v_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns #1 after the post-th clock following the vsync fall numbered target
    // (post=2 is the edge where the decoder registers the frame boundary).
    task automatic wait_vf(input int target, input int post);
        int n = 0;
        while (vf_cnt < target && n < 20000) begin
            @(posedge CLK);
            n++;
        end
        chk("wait_vf_in_time", 32'(vf_cnt >= target), 1);
        repeat (post) @(posedge CLK);
        #1;
    endtask

    // Decoder HPOS trails the driven horizontal count by 2 when sampled #1 after an edge.
    task automatic wait_pos(input int v, input int h);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 20000) begin
            @(posedge CLK);
            #1;
            n++;
            hit = (drv_v == v && drv_h == h);
        end
        chk("wait_pos_in_time", 32'(hit), 1);
    endtask

    task automatic wait_lock(input int budget);
        int n = 0;
        while (!LOCKED && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("relock_in_time", 32'(LOCKED), 1);
    endtask

    initial begin : main
        int base;
        int n;
        bit seen;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_hpos", 32'(HPOS), 0);
        chk("rst_vpos", 32'(VPOS), 0);
        chk("rst_locked", 32'(LOCKED), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_line_len", 32'(LINE_LEN), 0);
        chk("rst_frame_lines", 32'(FRAME_LINES), 0);
        chk("rst_active", 32'(ACTIVE), 0);
        RST = 1'b0;
        gen_en = 1;

        // lock acquisition: boundaries 1..4 -> LOCKED on the 4th
        wait_vf(3, 2);
        chk("lock_not_at_vf3", 32'(LOCKED), 0);
        wait_vf(4, 1);
        chk("lock_not_before_edge", 32'(LOCKED), 0);
        @(posedge CLK);
        #1;
        chk("lock_at_vf4", 32'(LOCKED), 1);
        chk("line_len", 32'(LINE_LEN), 99);
        chk("frame_lines", 32'(FRAME_LINES), 9);
        chk("no_err_on_lock", 32'(ERR), 0);
        // vsync and hsync fall together
        chk("boundary_hpos", 32'(HPOS), 0);
        chk("boundary_vpos", 32'(VPOS), 0);
        wait_pos(1, 2);
        chk("line1_vpos", 32'(VPOS), 1);
        chk("line1_hpos", 32'(HPOS), 0);
        wait_pos(9, 50);
        chk("line9_vpos", 32'(VPOS), 9);
        chk("line9_hpos", 32'(HPOS), 48);
        wait_vf(5, 2);
        chk("vf5_vpos", 32'(VPOS), 0);
        chk("vf5_frame_lines", 32'(FRAME_LINES), 9);
        chk("vf5_locked", 32'(LOCKED), 1);

        // data window on a tall frame while still locked
        next_mode = 1;
        wait_vf(6, 0);
        next_mode = 0;
        wait_pos(33, 152);
        chk("v33_vpos", 32'(VPOS), 33);
        chk("v33_hpos", 32'(HPOS), 150);
        chk("v33_active", 32'(ACTIVE), 0);
        wait_pos(34, 144);
        chk("h142_active", 32'(ACTIVE), 0);
        wait_pos(34, 145);
        chk("h143_hpos", 32'(HPOS), 143);
        chk("h143_v34_active", 32'(ACTIVE), 1);
        wait_pos(34, 784);
        chk("h782_active", 32'(ACTIVE), 1);
        wait_pos(34, 785);
        chk("h783_active", 32'(ACTIVE), 0);
        wait_pos(513, 145);
        chk("v513_vpos", 32'(VPOS), 513);
        chk("v513_active", 32'(ACTIVE), 1);
        wait_pos(514, 145);
        chk("v514_active", 32'(ACTIVE), 0);
        chk("window_locked", 32'(LOCKED), 1);
        wait_vf(7, 2);
        chk("tall_frame_err", 32'(ERR), 1);
        chk("tall_frame_unlock", 32'(LOCKED), 0);
        @(posedge CLK);
        #1;
        chk("tall_frame_err_1cyc", 32'(ERR), 0);
        wait_vf(10, 2);
        chk("relock_not_at_vf10", 32'(LOCKED), 0);
        wait_vf(11, 2);
        chk("relock_at_vf11", 32'(LOCKED), 1);
        chk("relock_line_len", 32'(LINE_LEN), 99);

        // one line lengthened by two cycles
        stretch_req = 1;
        wait_vf(12, 2);
        chk("stretch_err", 32'(ERR), 1);
        chk("stretch_unlock", 32'(LOCKED), 0);
        @(posedge CLK);
        #1;
        chk("stretch_err_1cyc", 32'(ERR), 0);
        wait_vf(15, 2);
        chk("stretch_not_at_vf15", 32'(LOCKED), 0);
        wait_vf(16, 2);
        chk("stretch_relock_vf16", 32'(LOCKED), 1);

        // hsync held high -> HPOS saturates, timeout
        wait_pos(5, 50);
        hs_kill = 1;
        n = 0;
        while (!ERR && n < 2000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("timeout_err", 32'(ERR), 1);
        chk("timeout_hpos", 32'(HPOS), 1023);
        chk("timeout_unlock", 32'(LOCKED), 0);
        seen = 0;
        repeat (400) begin
            @(posedge CLK);
            #1;
            if (ERR) seen = 1;
        end
        chk("timeout_no_repeat_err", 32'(seen), 0);
        chk("timeout_hpos_held", 32'(HPOS), 1023);
        hs_kill = 0;
        wait_lock(10000);
        chk("timeout_relock_line_len", 32'(LINE_LEN), 99);
        chk("timeout_relock_frame_lines", 32'(FRAME_LINES), 9);

        // one-cycle reset while locked, mid-frame with both syncs high
        wait_pos(5, 50);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("midrst_hpos", 32'(HPOS), 0);
        chk("midrst_vpos", 32'(VPOS), 0);
        chk("midrst_locked", 32'(LOCKED), 0);
        chk("midrst_line_len", 32'(LINE_LEN), 0);
        chk("midrst_frame_lines", 32'(FRAME_LINES), 0);
        chk("midrst_err", 32'(ERR), 0);
        base = vf_cnt;
        wait_vf(base + 3, 2);
        chk("midrst_not_at_3", 32'(LOCKED), 0);
        wait_vf(base + 4, 2);
        chk("midrst_lock_at_4", 32'(LOCKED), 1);
        chk("midrst_line_len_relock", 32'(LINE_LEN), 99);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
